fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the control unit. It owns the PC register and issues word requests to a request/response instruction memory that may have wait states. It holds the IF/ID register (instruction, PC, valid) that decode consumes, and supports stall, redirect (branch/jump), and a 1-entry skid buffer.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_skid_buffer.sv | 48 ++++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction-fetch stage:
//            fetch FSM state encoding, NOP encoding, default reset PC,
//            the {instruction, pc} packet, and a word-alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // WAIT tags the single outstanding request. DISCARD waits out a
    // response that a redirect has made stale.
    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } FetchState;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } FetchPacket;

    // Clears the byte-offset bits so that every fetch address is a word address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_buffer
// Purpose  : One-entry holding slot for a fetched packet that arrives while
//            decode is stalled.
// Ports    : i_clk, i_rst_n (async active-low)
//            i_load/i_packet - capture a packet
//            i_drain         - release the entry (decode took it)
//            i_clear         - squash the entry (redirect)
//            o_valid/o_packet - current contents
// Revision : 1.0 - initial release
// ============================================================================
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  FetchPacket i_packet,
    input  logic       i_drain,
    input  logic       i_clear,
    output logic       o_valid,
    output FetchPacket o_packet
);

    logic       r_valid;
    FetchPacket r_packet;

    // Clear has priority: a redirect invalidates anything fetched before it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid  <= 1'b0;
            r_packet <= '{instruction: NOP_INSTR, pc: 32'h0};
        end else if (i_clear) begin
            r_valid  <= 1'b0;
        end else if (i_load) begin
            r_valid  <= 1'b1;
            r_packet <= i_packet;
        end else if (i_drain) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_packet = r_packet;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Owns the PC, issues one word request at
//            a time to a req/gnt/rvalid instruction memory, and holds the
//            IF/ID register consumed by decode. Supports stall, redirect and a
//            one-entry skid buffer for responses arriving under stall.
// Ports    : iClk, iRstN (async active-low)
//            iStall, iRedirect, iRedirectTarget - from decode/control
//            oImemReq, oImemAddr, iImemGnt, iImemRvalid, iImemRdata - memory
//            oValid, oInstruction, oPC, oPCPlus4 - IF/ID register
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          XLEN     = 32   // only 32 is supported
) (
    input  logic            iClk,
    input  logic            iRstN,
    input  logic            iStall,
    input  logic            iRedirect,
    input  logic [XLEN-1:0] iRedirectTarget,
    output logic            oImemReq,
    output logic [XLEN-1:0] oImemAddr,
    input  logic            iImemGnt,
    input  logic            iImemRvalid,
    input  logic [XLEN-1:0] iImemRdata,
    output logic            oValid,
    output logic [XLEN-1:0] oInstruction,
    output logic [XLEN-1:0] oPC,
    output logic [XLEN-1:0] oPCPlus4
);

    FetchState   r_state;
    FetchState   w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_inflight;

    logic        w_req;
    logic        w_grant;
    logic        w_deliver;
    logic        w_skid_valid;
    FetchPacket  w_skid_packet;
    FetchPacket  w_rsp_packet;

    logic        r_valid;
    logic [31:0] r_instruction;
    logic [31:0] r_id_pc;

    // Requests stop while the skid slot is occupied so a second response can
    // never arrive with nowhere to go.
    assign w_req     = (r_state == ISSUE) && !w_skid_valid;
    assign w_grant   = w_req && iImemGnt;
    // A response is usable only in WAIT and only if no redirect squashes it.
    assign w_deliver = (r_state == WAIT) && iImemRvalid && !iRedirect;

    assign w_rsp_packet = '{instruction: iImemRdata, pc: r_inflight};

    // The request is forced low while reset is held, without feeding the reset
    // into any flop data path.
    assign oImemReq  = w_req && iRstN;
    assign oImemAddr = r_pc;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            ISSUE: begin
                if (w_grant) begin
                    w_pc_next    = r_pc + 32'd4;
                    // A redirect in the grant cycle orphans the new request.
                    w_state_next = iRedirect ? DISCARD : WAIT;
                end
            end
            WAIT: begin
                if (iImemRvalid) begin
                    w_state_next = ISSUE;
                end else if (iRedirect) begin
                    w_state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (iImemRvalid) begin
                    w_state_next = ISSUE;
                end
            end
            default: w_state_next = ISSUE;
        endcase
        if (iRedirect) begin
            w_pc_next = word_align(iRedirectTarget);
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state    <= ISSUE;
            r_pc       <= RESET_PC;
            r_inflight <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_grant) begin
                r_inflight <= r_pc;
            end
        end
    end

    fetch_skid_buffer u_skid (
        .i_clk    (iClk),
        .i_rst_n  (iRstN),
        .i_load   (w_deliver && iStall),
        .i_packet (w_rsp_packet),
        .i_drain  (!iStall),
        .i_clear  (iRedirect),
        .o_valid  (w_skid_valid),
        .o_packet (w_skid_packet)
    );

    // IF/ID register. The skid entry is older than any new response, so it
    // is drained first; with no source a bubble is inserted.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_valid       <= 1'b0;
            r_instruction <= NOP_INSTR;
            r_id_pc       <= 32'h0;
        end else if (iRedirect) begin
            r_valid       <= 1'b0;
            r_instruction <= NOP_INSTR;
        end else if (!iStall) begin
            if (w_skid_valid) begin
                r_valid       <= 1'b1;
                r_instruction <= w_skid_packet.instruction;
                r_id_pc       <= w_skid_packet.pc;
            end else if (w_deliver) begin
                r_valid       <= 1'b1;
                r_instruction <= w_rsp_packet.instruction;
                r_id_pc       <= w_rsp_packet.pc;
            end else begin
                r_valid       <= 1'b0;
                r_instruction <= NOP_INSTR;
            end
        end
    end

    assign oValid       = r_valid;
    assign oInstruction = r_instruction;
    assign oPC          = r_id_pc;
    assign oPCPlus4     = r_id_pc + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: directed cycle tables for the
//            stall / redirect / wrap corner cases, an async-reset sequence,
//            and a randomized run checked against an instruction-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        iClk;
    logic        iRstN;
    logic        iStall;
    logic        iRedirect;
    logic [31:0] iRedirectTarget;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemGnt;
    logic        iImemRvalid;
    logic [31:0] iImemRdata;
    logic        oValid;
    logic [31:0] oInstruction;
    logic [31:0] oPC;
    logic [31:0] oPCPlus4;

    fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .iClk            (iClk),
        .iRstN           (iRstN),
        .iStall          (iStall),
        .iRedirect       (iRedirect),
        .iRedirectTarget (iRedirectTarget),
        .oImemReq        (oImemReq),
        .oImemAddr       (oImemAddr),
        .iImemGnt        (iImemGnt),
        .iImemRvalid     (iImemRvalid),
        .iImemRdata      (iImemRdata),
        .oValid          (oValid),
        .oInstruction    (oInstruction),
        .oPC             (oPC),
        .oPCPlus4        (oPCPlus4)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    // Memory model state: at most one pending response.
    logic        mem_pending;
    logic [31:0] mem_addr;
    int          mem_cnt;

    // ctl = {gnt, stall, redirect, hold_response}
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] target;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[29];
    vec_t wrp[8];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] tgt,
                                input logic req, input logic [31:0] addr,
                                input logic vld, input logic [31:0] pc);
        vec_t v;
        v.ctl = ctl; v.target = tgt; v.exp_req = req; v.exp_addr = addr;
        v.exp_valid = vld; v.exp_pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req"},    {31'b0, oImemReq}, 32'd0);
        chk({tag, " valid"},  {31'b0, oValid},   32'd0);
        chk({tag, " instr"},  oInstruction,      c_nop);
        chk({tag, " pc"},     oPC,               32'h0);
        chk({tag, " pc4"},    oPCPlus4,          32'h4);
    endtask

    task automatic do_reset();
        iRstN = 1'b0;
        iStall = 1'b0; iRedirect = 1'b0; iRedirectTarget = 32'h0;
        iImemGnt = 1'b0; iImemRvalid = 1'b0; iImemRdata = 32'h0;
        mem_pending = 1'b0; mem_addr = 32'h0; mem_cnt = 0;
        repeat (2) @(negedge iClk);
        chk_reset_outputs("reset");
        iRstN = 1'b1;
    endtask

    // One directed cycle: drive at negedge, compare before the next posedge,
    // then advance the memory model from what was seen before the edge.
    task automatic apply_row(input vec_t v, input string tag);
        logic        req_s;
        logic [31:0] addr_s;
        logic        rv;
        @(negedge iClk);
        iImemGnt        = v.ctl[3];
        iStall          = v.ctl[2];
        iRedirect       = v.ctl[1];
        iRedirectTarget = v.target;
        rv              = mem_pending && !v.ctl[0];
        iImemRvalid     = rv;
        iImemRdata      = rv ? mem_data(mem_addr) : 32'hDEAD_BEEF;
        #1;
        chk({tag, " req"}, {31'b0, oImemReq}, {31'b0, v.exp_req});
        if (v.exp_req) chk({tag, " addr"}, oImemAddr, v.exp_addr);
        chk({tag, " valid"}, {31'b0, oValid}, {31'b0, v.exp_valid});
        if (v.exp_valid) begin
            chk({tag, " pc"},    oPC,          v.exp_pc);
            chk({tag, " instr"}, oInstruction, mem_data(v.exp_pc));
            chk({tag, " pc4"},   oPCPlus4,     v.exp_pc + 32'd4);
        end else begin
            chk({tag, " nop"}, oInstruction, c_nop);
        end
        req_s  = oImemReq;
        addr_s = oImemAddr;
        @(posedge iClk);
        if (rv) mem_pending = 1'b0;
        if (req_s && v.ctl[3]) begin
            mem_pending = 1'b1;
            mem_addr    = addr_s;
        end
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          consumed;
        logic        rv, s_req, s_valid, s_gnt, s_stall, s_redir;
        logic [31:0] s_addr, s_pc, s_tgt;
        logic        prev_hold;
        logic [31:0] prev_addr;

        // Directed main sequence (1-cycle latency unless hold is set).
        tbl[0]  = mk(4'b1000, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0);
        tbl[1]  = mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        tbl[2]  = mk(4'b1000, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0);
        tbl[3]  = mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        tbl[4]  = mk(4'b1100, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4);   // stall begins
        tbl[5]  = mk(4'b0100, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4);   // 0x8 -> skid
        tbl[6]  = mk(4'b1100, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4);   // skid full, no req
        tbl[7]  = mk(4'b1000, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4);   // release
        tbl[8]  = mk(4'b0000, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8);
        tbl[9]  = mk(4'b0000, 32'h0,   1'b1, 32'hC,   1'b0, 32'h0);   // gnt withheld
        tbl[10] = mk(4'b0000, 32'h0,   1'b1, 32'hC,   1'b0, 32'h0);
        tbl[11] = mk(4'b1000, 32'h0,   1'b1, 32'hC,   1'b0, 32'h0);
        tbl[12] = mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        tbl[13] = mk(4'b1000, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC);
        tbl[14] = mk(4'b0011, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0);   // redirect in WAIT
        tbl[15] = mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);   // 0x10 dropped
        tbl[16] = mk(4'b1000, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0);
        tbl[17] = mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        tbl[18] = mk(4'b1000, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100);
        tbl[19] = mk(4'b0110, 32'h203, 1'b0, 32'h0,   1'b0, 32'h0);   // redirect+stall+rvalid
        tbl[20] = mk(4'b0000, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0);
        tbl[21] = mk(4'b1000, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0);
        tbl[22] = mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        tbl[23] = mk(4'b1010, 32'h300, 1'b1, 32'h204, 1'b1, 32'h200); // redirect on grant
        tbl[24] = mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        tbl[25] = mk(4'b0010, 32'h400, 1'b1, 32'h300, 1'b0, 32'h0);   // redirect, no grant
        tbl[26] = mk(4'b1000, 32'h0,   1'b1, 32'h400, 1'b0, 32'h0);
        tbl[27] = mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        tbl[28] = mk(4'b1100, 32'h0,   1'b1, 32'h404, 1'b1, 32'h400);

        // PC wrap and redirect while already discarding.
        wrp[0] = mk(4'b0010, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0, 32'h0);
        wrp[1] = mk(4'b1000, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        wrp[2] = mk(4'b0000, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0);
        wrp[3] = mk(4'b1000, 32'h0,         1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC);
        wrp[4] = mk(4'b0011, 32'h40,        1'b0, 32'h0,         1'b0, 32'h0);
        wrp[5] = mk(4'b0011, 32'h80,        1'b0, 32'h0,         1'b0, 32'h0);
        wrp[6] = mk(4'b0000, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0);
        wrp[7] = mk(4'b0000, 32'h0,         1'b1, 32'h80,        1'b0, 32'h0);

        do_reset();
        for (int i = 0; i < 29; i++) apply_row(tbl[i], $sformatf("row%0d", i));

        // Async reset while a request is outstanding and IF/ID is valid.
        @(negedge iClk);
        iImemGnt = 1'b0; iImemRvalid = 1'b0; iRedirect = 1'b0; iStall = 1'b1;
        #1;
        chk("pre_reset valid", {31'b0, oValid}, 32'd1);
        #1;
        iRstN = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        mem_pending = 1'b0;
        @(negedge iClk);
        iStall = 1'b0;
        iRstN  = 1'b1;

        for (int i = 0; i < 8; i++) apply_row(wrp[i], $sformatf("wrap%0d", i));

        // Randomized run against the instruction-stream model: every
        // instruction decode accepts must be the next address in program
        // order, restarting at the aligned target after each redirect.
        do_reset();
        exp_pc    = 32'h0;
        consumed  = 0;
        prev_hold = 1'b0;
        prev_addr = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge iClk);
            rv              = mem_pending && (mem_cnt == 0);
            iImemRvalid     = rv;
            iImemRdata      = rv ? mem_data(mem_addr) : $urandom;
            iImemGnt        = ($urandom_range(0, 3) != 0);
            iStall          = ($urandom_range(0, 3) == 0);
            iRedirect       = ($urandom_range(0, 19) == 0);
            iRedirectTarget = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                          : ($urandom & 32'h0000_3FFF);
            #1;
            if (oValid) begin
                chk("rnd instr", oInstruction, mem_data(oPC));
                chk("rnd pc4",   oPCPlus4,     oPC + 32'd4);
            end else begin
                chk("rnd nop", oInstruction, c_nop);
            end
            chk("rnd one_outstanding", {31'b0, oImemReq && mem_pending}, 32'd0);
            if (prev_hold) begin
                chk("rnd req_held",    {31'b0, oImemReq}, 32'd1);
                chk("rnd addr_stable", oImemAddr,         prev_addr);
            end
            s_req = oImemReq; s_addr = oImemAddr; s_valid = oValid; s_pc = oPC;
            s_gnt = iImemGnt; s_stall = iStall; s_redir = iRedirect; s_tgt = iRedirectTarget;
            @(posedge iClk);
            if (s_valid && !s_stall) begin
                chk("rnd stream_pc", s_pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (s_redir) exp_pc = s_tgt & ~32'h3;
            if (rv) mem_pending = 1'b0;
            else if (mem_pending) mem_cnt--;
            if (s_req && s_gnt) begin
                mem_pending = 1'b1;
                mem_addr    = s_addr;
                mem_cnt     = $urandom_range(0, 2);
            end
            prev_hold = s_req && !s_gnt && !s_redir;
            prev_addr = s_addr;
        end
        chk("rnd progress", {31'b0, consumed > 100}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
